// File: rtl/sync_loop_ctrl.sv
// Symbol-timing loop sequencer: runs the loop through clear, acquisition and tracking, and declares or drops lock from the averaged error magnitude.
// All outputs are registered and change one edge after the qualifying input. There is no backpressure: every input is sampled on every cycle.
module sync_loop_ctrl #(
    parameter int SYM_WIDTH    = 1,
    parameter int INT_WIDTH    = 1,
    parameter int DEC_WIDTH    = 14,
    parameter int ACQ_SYMS     = 64,
    parameter int LOCK_THRESH  = 'h0400,
    parameter int LOCK_COUNT   = 32,
    parameter int UNLOCK_COUNT = 16,
    parameter int AVG_SHIFT    = 3,
    parameter int KP_ACQ       = 2,
    parameter int KI_ACQ       = 6,
    parameter int KP_TRK       = 5,
    parameter int KI_TRK       = 10
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enable,
    input  logic                                     mk,
    input  logic                                     err_valid,
    input  logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] err_data,
    output logic                                     loop_clr,
    output logic [3:0]                               kp_shift,
    output logic [3:0]                               ki_shift,
    output logic [2:0]                               state,
    output logic                                     locked,
    output logic                                     lost_lock,
    output logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] err_avg
);
    localparam int W          = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int CNT_W      = 16;
    localparam int CLR_CYCLES = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_TRACK   = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [W-1:0]        r_avg;
    logic                r_loop_clr;
    logic                r_locked;
    logic                r_lost_lock;
    logic [3:0]          r_kp;
    logic [3:0]          r_ki;

    state_t              w_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_lost;
    logic                w_good;
    logic [W-1:0]        w_abs;
    logic [W-1:0]        w_avg_upd;
    logic [W-1:0]        w_avg_next;
    logic signed [W+1:0] w_diff;
    logic signed [W+1:0] w_step;
    logic signed [W+1:0] w_sum;

    // Two guard bits keep the difference and sum exact before clamping.
    always_comb begin
        if (err_data == {1'b1, {(W-1){1'b0}}}) begin
            w_abs = {1'b0, {(W-1){1'b1}}};
        end else if (err_data[W-1]) begin
            w_abs = -err_data;
        end else begin
            w_abs = err_data;
        end
        w_diff = $signed({2'b00, w_abs}) - $signed({2'b00, r_avg});
        w_step = w_diff >>> AVG_SHIFT;
        w_sum  = $signed({2'b00, r_avg}) + w_step;
        if (w_sum[W+1]) begin
            w_avg_upd = '0;
        end else if (w_sum[W] || w_sum[W-1]) begin
            w_avg_upd = {1'b0, {(W-1){1'b1}}};
        end else begin
            w_avg_upd = {1'b0, w_sum[W-2:0]};
        end
        if (!enable || r_state == S_IDLE || r_state == S_CLEAR) begin
            w_avg_next = '0;
        end else if (err_valid) begin
            w_avg_next = w_avg_upd;
        end else begin
            w_avg_next = r_avg;
        end
    end

    assign w_good    = (r_avg < W'(LOCK_THRESH));
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_lost     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_CLEAR;
            S_CLEAR: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc >= CNT_W'(CLR_CYCLES)) w_next = S_ACQUIRE;
            end
            S_ACQUIRE: begin
                if (mk) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc >= CNT_W'(ACQ_SYMS)) w_next = S_TRACK;
                end
            end
            S_TRACK: begin
                if (err_valid) begin
                    if (w_good) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(LOCK_COUNT)) w_next = S_LOCKED;
                    end else begin
                        w_cnt_next = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (err_valid) begin
                    if (!w_good) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc >= CNT_W'(UNLOCK_COUNT)) begin
                            w_next = S_CLEAR;
                            w_lost = 1'b1;
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        // The shared counter restarts on every state change; a dropped enable wins over everything.
        if (!enable) begin
            w_next = S_IDLE;
            w_lost = 1'b0;
        end
        if (w_next != r_state) w_cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_avg       <= '0;
            r_loop_clr  <= 1'b0;
            r_locked    <= 1'b0;
            r_lost_lock <= 1'b0;
            r_kp        <= 4'(KP_ACQ);
            r_ki        <= 4'(KI_ACQ);
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_avg       <= w_avg_next;
            r_loop_clr  <= (w_next == S_CLEAR);
            r_locked    <= (w_next == S_LOCKED);
            r_lost_lock <= w_lost;
            r_kp        <= (w_next == S_TRACK || w_next == S_LOCKED) ? 4'(KP_TRK) : 4'(KP_ACQ);
            r_ki        <= (w_next == S_TRACK || w_next == S_LOCKED) ? 4'(KI_TRK) : 4'(KI_ACQ);
        end
    end

    assign state     = r_state;
    assign loop_clr  = r_loop_clr;
    assign locked    = r_locked;
    assign lost_lock = r_lost_lock;
    assign kp_shift  = r_kp;
    assign ki_shift  = r_ki;
    assign err_avg   = r_avg;

endmodule

// File: tb/tb_sync_loop_ctrl.sv
// Bench for sync_loop_ctrl: vector table, directed lock/unlock/enable sequences, and random traffic against a behavioural model.
module tb_sync_loop_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, mk, err_valid;
    logic [15:0] err_data;
    logic        loop_clr, locked, lost_lock;
    logic [3:0]  kp_shift, ki_shift;
    logic [2:0]  state;
    logic [15:0] err_avg;

    logic        en2, mk2, ev2;
    logic [15:0] dat2;
    logic        loop_clr2, locked2, lost_lock2;
    logic [3:0]  kp2, ki2;
    logic [2:0]  state2;
    logic [15:0] avg2;

    sync_loop_ctrl u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mk(mk), .err_valid(err_valid), .err_data(err_data),
        .loop_clr(loop_clr), .kp_shift(kp_shift), .ki_shift(ki_shift), .state(state),
        .locked(locked), .lost_lock(lost_lock), .err_avg(err_avg)
    );

    sync_loop_ctrl #(.AVG_SHIFT(0)) u_sat (
        .clk(clk), .rst(rst), .enable(en2), .mk(mk2), .err_valid(ev2), .err_data(dat2),
        .loop_clr(loop_clr2), .kp_shift(kp2), .ki_shift(ki2), .state(state2),
        .locked(locked2), .lost_lock(lost_lock2), .err_avg(avg2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int avg_ref(input int avg, input logic [15:0] x, input int sh);
        int v, a, d, step, r;
        v = $signed(x);
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        d = a - avg;
        if (d >= 0) step = d / (1 << sh);
        else        step = -((-d + (1 << sh) - 1) / (1 << sh));
        r = avg + step;
        if (r < 0) r = 0;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    // Behavioural model: states 0..4 as numbered in the interface, one named counter per activity.
    int m_state, m_avg, m_clr, m_syms, m_good, m_bad, m_ns, m_navg;
    bit m_lost, m_valid = 0, m_ok, m_lnext;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_avg = 0; m_clr = 0; m_syms = 0; m_good = 0; m_bad = 0;
            m_lost = 0; m_valid = 1;
        end else if (!enable) begin
            m_state = 0; m_avg = 0; m_clr = 0; m_syms = 0; m_good = 0; m_bad = 0;
            m_lost = 0;
        end else begin
            m_ns = m_state;
            m_lnext = 0;
            m_ok = (m_avg < 'h400);
            if (m_state <= 1)  m_navg = 0;
            else if (err_valid) m_navg = avg_ref(m_avg, err_data, 3);
            else               m_navg = m_avg;
            case (m_state)
                0: m_ns = 1;
                1: begin m_clr++; if (m_clr == 4) m_ns = 2; end
                2: if (mk) begin m_syms++; if (m_syms == 64) m_ns = 3; end
                3: if (err_valid) begin
                       m_good = m_ok ? m_good + 1 : 0;
                       if (m_good == 32) m_ns = 4;
                   end
                4: if (err_valid) begin
                       m_bad = m_ok ? 0 : m_bad + 1;
                       if (m_bad == 16) begin m_ns = 1; m_lnext = 1; end
                   end
                default: m_ns = 0;
            endcase
            if (m_ns != m_state) begin m_clr = 0; m_syms = 0; m_good = 0; m_bad = 0; end
            m_state = m_ns;
            m_avg = m_navg;
            m_lost = m_lnext;
        end
    end

    task automatic tick();
        int exp_flags;
        @(posedge clk);
        #1;
        if (m_valid) begin
            exp_flags = {23'd0, (m_state == 1), (m_state == 4), m_lost,
                         (m_state >= 3) ? 4'd5 : 4'd2, (m_state >= 3) ? 4'd10 : 4'd6};
            chk("mdl_state", state, m_state);
            chk("mdl_avg", err_avg, m_avg);
            chk("mdl_flags", {23'd0, loop_clr, locked, lost_lock, kp_shift, ki_shift}, exp_flags);
        end
    endtask

    typedef struct {
        logic        ev;
        logic [15:0] dat;
        int          exp_avg;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog state=%0d expected finish", state);
        $fatal(1, "timeout");
    end

    initial begin
        int e, pre, bad, good, total;
        bit done;
        logic [15:0] mag;

        tbl[0] = '{1'b1, 16'h0100, 32};
        tbl[1] = '{1'b1, 16'hFF00, 60};
        tbl[2] = '{1'b1, 16'h8000, 4148};
        tbl[3] = '{1'b1, 16'h0000, 3629};
        tbl[4] = '{1'b1, 16'h7FFF, 7271};
        tbl[5] = '{1'b1, 16'hFFFF, 6362};
        tbl[6] = '{1'b0, 16'h4000, 6362};

        rst = 1; enable = 1; mk = 0; err_valid = 0; err_data = 0;
        en2 = 0; mk2 = 0; ev2 = 0; dat2 = 0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_loop_clr", loop_clr, 0);
        chk("rst_kp", kp_shift, 2);
        chk("rst_ki", ki_shift, 6);
        chk("rst_avg", err_avg, 0);

        rst = 0;
        tick();
        chk("clr_entry_state", state, 1);
        chk("clr_entry_loop_clr", loop_clr, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_hold_state", state, 1);
            chk("clr_hold_loop_clr", loop_clr, 1);
        end
        tick();
        chk("acq_entry_state", state, 2);
        chk("acq_entry_loop_clr", loop_clr, 0);

        foreach (tbl[i]) begin
            err_valid = tbl[i].ev;
            err_data  = tbl[i].dat;
            tick();
            chk("tbl_avg", err_avg, tbl[i].exp_avg);
            chk("tbl_state", state, 2);
        end
        err_valid = 0;

        for (int i = 0; i < 30; i++) begin
            mk = 1; tick(); mk = 0; tick();
        end
        chk("drop_pre_state", state, 2);
        enable = 0;
        tick();
        chk("drop_state", state, 0);
        chk("drop_avg", err_avg, 0);
        chk("drop_loop_clr", loop_clr, 0);
        chk("drop_kp", kp_shift, 2);
        enable = 1;
        tick();
        chk("reen_state", state, 1);
        chk("reen_loop_clr", loop_clr, 1);
        repeat (3) tick();
        tick();
        chk("reen_acq", state, 2);

        err_valid = 1; err_data = 16'h0100;
        for (int s = 1; s <= 64; s++) begin
            mk = 1; tick(); mk = 0;
            if (s == 63) chk("acq_63_state", state, 2);
            if (s == 64) begin
                chk("acq_64_state", state, 3);
                chk("trk_kp", kp_shift, 5);
                chk("trk_ki", ki_shift, 10);
                chk("trk_avg", err_avg, 249);
            end else begin
                repeat (7) tick();
            end
        end

        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 31) begin
                chk("lock_31_state", state, 3);
                chk("lock_31_locked", locked, 0);
            end
        end
        chk("lock_state", state, 4);
        chk("lock_locked", locked, 1);
        chk("lock_avg", err_avg, 249);

        e = 249; bad = 0; done = 0;
        err_data = 16'h2000;
        for (int k = 0; k < 100 && !done; k++) begin
            pre = e;
            e = avg_ref(e, 16'h2000, 3);
            bad = (pre >= 'h400) ? bad + 1 : 0;
            tick();
            chk("unl_avg", err_avg, e);
            if (bad == 16) begin
                done = 1;
                chk("unl_state", state, 1);
                chk("unl_locked", locked, 0);
                chk("unl_lost", lost_lock, 1);
                chk("unl_loop_clr", loop_clr, 1);
            end else begin
                chk("unl_hold", state, 4);
            end
        end
        chk("unl_reached", done, 1);
        err_valid = 0;
        tick();
        chk("unl_lost_fall", lost_lock, 0);
        chk("unl_clr2_state", state, 1);
        chk("unl_clr2_loop_clr", loop_clr, 1);
        tick(); tick();
        chk("unl_clr4_loop_clr", loop_clr, 1);
        tick();
        chk("unl_acq_state", state, 2);
        chk("unl_acq_loop_clr", loop_clr, 0);

        err_valid = 1; err_data = 16'h0100;
        for (int s = 1; s <= 64; s++) begin
            mk = 1; tick(); mk = 0;
            if (s < 64) repeat (7) tick();
        end
        chk("reacq_state", state, 3);
        repeat (20) tick();
        err_data = 16'h7000;
        tick();
        e = avg_ref(249, 16'h7000, 3);
        chk("inj_avg", err_avg, e);
        good = 21; total = 21; done = 0;
        err_data = 16'h0100;
        for (int k = 0; k < 300 && !done; k++) begin
            pre = e;
            e = avg_ref(e, 16'h0100, 3);
            good = (pre < 'h400) ? good + 1 : 0;
            total++;
            tick();
            if (total == 32) chk("inj_no_lock_at_32", locked, 0);
            if (good == 32) begin
                done = 1;
                chk("inj_lock_state", state, 4);
                chk("inj_lock_locked", locked, 1);
            end else if (good == 31) begin
                chk("inj_pre_lock", locked, 0);
            end
        end
        chk("inj_reached", done, 1);

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            enable    = ($urandom_range(0, 399) != 0);
            mk        = ($urandom_range(0, 2) == 0);
            err_valid = 1'($urandom_range(0, 1));
            if ((i / 400) % 4 == 3 || $urandom_range(0, 63) == 0)
                mag = 16'($urandom_range('h800, 'h7FFF));
            else
                mag = 16'($urandom_range(0, 'h300));
            err_data = $urandom_range(0, 1) ? -mag : mag;
            if ($urandom_range(0, 99) == 0) err_data = 16'h8000;
            tick();
        end

        rst = 0; enable = 0; mk = 0; err_valid = 0;
        en2 = 1;
        repeat (5) tick();
        chk("sat_acq_state", state2, 2);
        ev2 = 1; dat2 = 16'h8000;
        tick(); chk("sat_avg_1", avg2, 'h7FFF);
        tick(); chk("sat_avg_2", avg2, 'h7FFF);
        dat2 = 16'h0001;
        tick(); chk("sat_avg_small", avg2, 1);
        dat2 = 16'h8000;
        tick(); chk("sat_avg_3", avg2, 'h7FFF);
        dat2 = 16'hFFFF;
        tick(); chk("sat_avg_neg1", avg2, 1);
        dat2 = 16'h8001;
        tick(); chk("sat_avg_negmax", avg2, 'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_loop_ctrl.md
# sync_loop_ctrl

Sequencing controller for the symbol-timing recovery loop (interpolator, error detector, loop filter, timing control). Runs the loop through reset, wide-bandwidth acquisition and narrow-bandwidth tracking. Supplies the loop-filter gain shifts and a loop clear. Declares and drops symbol-timing lock from a smoothed timing-error magnitude. Sits beside the loop, fed by the error-detector output and the `mk` symbol strobe.

## Interface
- `SYM_WIDTH`, default 1, sign bits of the error word
- `INT_WIDTH`, default 1, integer bits of the error word
- `DEC_WIDTH`, default 14, fraction bits of the error word (W = 16)
- `ACQ_SYMS`, default 64, `mk` strobes spent in acquisition
- `LOCK_THRESH`, default 16'h0400, lock threshold on the averaged error magnitude
- `LOCK_COUNT`, default 32, consecutive below-threshold error samples needed to lock
- `UNLOCK_COUNT`, default 16, consecutive at-or-above-threshold samples needed to drop lock
- `AVG_SHIFT`, default 3, smoothing shift of the magnitude averager
- `KP_ACQ`/`KI_ACQ`, default 2/6, gain shifts in acquisition
- `KP_TRK`/`KI_TRK`, default 5/10, gain shifts in tracking and locked
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `enable` in 1: level; run the loop when high
- `mk` in 1: one-cycle symbol strobe from timing control
- `err_valid` in 1: error sample strobe from the error detector
- `err_data` in W: signed error sample, Q1.14
- `loop_clr` out 1: clears the loop-filter integrator and the timing-control accumulator
- `kp_shift` out 4: proportional gain shift to the loop filter
- `ki_shift` out 4: integral gain shift to the loop filter
- `state` out 3: IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3, LOCKED=4
- `locked` out 1: symbol-timing lock
- `lost_lock` out 1: one-cycle pulse on a LOCKED→CLEAR transition
- `err_avg` out W: unsigned averaged error magnitude

## Operation
- **Magnitude**
  - `abs = |err_data|`.
  - 16'h8000 saturates to 16'h7FFF.
- **Averager**, updated only on `err_valid` in ACQUIRE, TRACK or LOCKED:
  - `diff = abs − err_avg`, 17-bit signed.
  - `err_avg += diff >>> AVG_SHIFT`, arithmetic shift (floor).
  - Result clamped to 0..16'h7FFF.
  - Cleared to 0 in IDLE and CLEAR.
- **Lock test:** on an `err_valid` cycle, compare the *pre-update* `err_avg` against `LOCK_THRESH` (strict `<` means good).
- **FSM transitions:**
  - IDLE → CLEAR when `enable` = 1.
  - CLEAR: `loop_clr` = 1 for exactly 4 cycles, then ACQUIRE.
  - ACQUIRE:
    - Count `mk` strobes.
    - On the `ACQ_SYMS`-th strobe → TRACK.
    - `err_valid` samples update the averager but are not lock-tested.
  - TRACK:
    - Good sample → `good_cnt += 1`; bad sample → `good_cnt = 0`.
    - When `good_cnt` reaches `LOCK_COUNT` → LOCKED.
  - LOCKED:
    - Bad sample → `bad_cnt += 1`; good sample → `bad_cnt = 0`.
    - When `bad_cnt` reaches `UNLOCK_COUNT` → CLEAR, with a `lost_lock` pulse.
- **Enable drop:** `enable` = 0 in any state → IDLE next cycle. Counters and averager are cleared and `loop_clr` is deasserted.
- **Gain shifts:**
  - IDLE, CLEAR, ACQUIRE → `KP_ACQ`/`KI_ACQ`.
  - TRACK, LOCKED → `KP_TRK`/`KI_TRK`.
- **Counters:**
  - Every counter is cleared on entry to each state.
  - Counters saturate and never wrap.
- **Simultaneous events:**
  - `mk` and `err_valid` in the same cycle are both processed.
  - `enable` = 0 overrides every other transition.

## Timing
- All outputs are registered. Reset values:
  - `state` = IDLE, `loop_clr` = 0, `locked` = 0, `lost_lock` = 0, `err_avg` = 0.
  - `kp_shift` = `KP_ACQ`, `ki_shift` = `KI_ACQ`.
- `rst` in any state, including mid-CLEAR or LOCKED, restores the reset values on the next edge.
- `state`, `kp_shift`, `ki_shift`, `locked` and `loop_clr` change on the same edge as the transition.
- **Transition latency:** the qualifying `mk` or `err_valid` cycle → new state one edge later.
- `loop_clr` is high for the 4 cycles that `state` = CLEAR. It falls on the edge `state` becomes ACQUIRE.
- `locked` = 1 exactly while `state` = LOCKED.
- `lost_lock` is high for the first cycle of CLEAR after LOCKED only.
- `err_avg` updates one edge after `err_valid`.

## Test plan
- **Reset:** `rst` high 2 cycles with `enable` = 1 → state 0, `locked` 0, `loop_clr` 0, `kp_shift` 2, `ki_shift` 6, `err_avg` 0. After release: CLEAR next edge, `loop_clr` high 4 cycles, then ACQUIRE.
- **Acquisition length:** 64 `mk` strobes spaced 8 cycles in ACQUIRE → state 3 one edge after the 64th strobe, `kp_shift` 5, `ki_shift` 10. A 63rd strobe alone leaves state 2.
- **Lock:** in TRACK, `err_data` = 16'h0100 on every `err_valid` → `err_avg` settles at 249. `locked` rises one edge after the 32nd sample. Injecting one 16'h7000 sample after 20 samples, then 16'h0100 again, delays lock until 32 fresh consecutive good samples follow the average returning below 16'h0400.
- **Unlock:** in LOCKED, `err_data` = 16'h2000 → after `err_avg` reaches ≥ 16'h0400, the 16th consecutive bad sample gives state 1, `locked` 0, a 1-cycle `lost_lock`, and `loop_clr` for 4 cycles.
- **Saturation:** `err_data` = 16'h8000 repeated with `AVG_SHIFT` = 0 → `err_avg` = 16'h7FFF, no wrap.
- **Enable drop:** `enable` low mid-ACQUIRE after 30 strobes → IDLE next edge, `err_avg` 0. Re-enable → full CLEAR and a fresh 64-strobe count.
